// File: rtl/readout_pkg.sv
// Shared types and constants for the channel readout scheduler.
// Address decode maps a register address onto its channel/register pair.
package readout_pkg;

  localparam int N_CH      = 8;
  localparam int N_REG     = 7;
  localparam int BASE_ADDR = 11;
  localparam int MAX_ADDR  = BASE_ADDR + N_CH * N_REG - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_FIN
  } scan_state_t;

  typedef struct packed {
    logic       ok;
    logic [2:0] ch;
    logic [2:0] rg;
  } dec_t;

  // Threshold compare chain; the last threshold passed gives the channel.
  function automatic dec_t addr_decode(input logic [6:0] addr);
    dec_t       d;
    logic [6:0] lo;
    d    = '0;
    d.ok = (addr >= 7'(BASE_ADDR)) && (addr <= 7'(MAX_ADDR));
    lo   = 7'(BASE_ADDR);
    for (int i = 0; i < N_CH; i++) begin
      if (addr >= lo) begin
        d.ch = 3'(i);
        d.rg = 3'(addr - lo);
      end
      lo = lo + 7'(N_REG);
    end
    if (!d.ok) d = '0;
    return d;
  endfunction

endpackage

// File: rtl/readout_scheduler_if.sv
// Item handshake between the scheduler and the readout serializer.
// The scheduler drives the item; the serializer answers with ready.
interface readout_scheduler_if;

  logic       item_valid;
  logic       item_ready;
  logic [6:0] item_addr;
  logic [2:0] item_ch;
  logic [2:0] item_reg;
  logic       item_src;

  modport master (
    output item_valid,
    output item_addr,
    output item_ch,
    output item_reg,
    output item_src,
    input  item_ready
  );

  modport slave (
    input  item_valid,
    input  item_addr,
    input  item_ch,
    input  item_reg,
    input  item_src,
    output item_ready
  );

endinterface

// File: rtl/readout_scheduler_next_enabled_ch.sv
// Finds the next enabled channel strictly above the current one.
// last is set when no enabled channel remains above cur.
module next_enabled_ch #(
  parameter int N = 8
) (
  input  logic [N-1:0] mask,
  input  logic [2:0]   cur,
  output logic [2:0]   nxt,
  output logic         last
);

  always_comb begin
    nxt  = cur;
    last = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (3'(i) > cur)) begin
        nxt  = 3'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/readout_scheduler.sv
// Walks the enabled channel registers and issues one read item at a time,
// letting single host reads jump ahead of the automatic scan.
module readout_scheduler #(
  parameter int N_CH      = 8,
  parameter int N_REG     = 7,
  parameter int BASE_ADDR = 11
) (
  input  logic                spi_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [N_CH-1:0]     ch_mask,
  input  logic                host_req,
  input  logic [6:0]          host_addr,
  output logic                host_gnt,
  output logic                host_err,
  readout_scheduler_if.master bus,
  output logic                busy,
  output logic                done
);

  import readout_pkg::*;

  scan_state_t     state;
  scan_state_t     state_n;
  logic [2:0]      ch_ptr;
  logic [2:0]      reg_ptr;
  logic [N_CH-1:0] mask_q;
  logic [N_CH-1:0] mask_eff;
  logic [2:0]      first_ch;
  logic [2:0]      scan_ch;
  logic [2:0]      scan_reg;
  logic [2:0]      adv_ch;
  logic            adv_last;
  logic            slot_free;
  logic            starting;
  logic            scan_on;
  logic            host_ok;
  logic            load_scan;
  logic            wrap;
  logic            last_item;
  logic [6:0]      scan_addr;
  dec_t            hdec;

  assign hdec      = addr_decode(host_addr);
  assign slot_free = !bus.item_valid || bus.item_ready;
  assign host_gnt  = host_req && slot_free && !abort && !rst;
  assign host_ok   = host_gnt && hdec.ok;

  assign starting  = (state == S_IDLE) && start && (|ch_mask);
  assign scan_on   = starting || (state == S_SCAN);
  assign mask_eff  = starting ? ch_mask : mask_q;

  always_comb begin
    first_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) first_ch = 3'(i);
    end
  end

  // The start edge itself loads the first item, so it reads the raw mask.
  assign scan_ch  = starting ? first_ch : ch_ptr;
  assign scan_reg = starting ? 3'd0 : reg_ptr;

  next_enabled_ch #(
    .N(N_CH)
  ) u_next (
    .mask(mask_eff),
    .cur (scan_ch),
    .nxt (adv_ch),
    .last(adv_last)
  );

  assign load_scan = slot_free && scan_on && !host_req && !abort;
  assign wrap      = (scan_reg == 3'(N_REG - 1));
  assign last_item = load_scan && wrap && adv_last;
  assign scan_addr = 7'(BASE_ADDR) + 7'(scan_ch) * 7'(N_REG) + 7'(scan_reg);

  assign busy = (state != S_IDLE);
  assign done = (state == S_FIN);

  always_ff @(posedge spi_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = (|ch_mask) ? S_SCAN : S_FIN;
      S_SCAN:  if (last_item) state_n = S_DRAIN;
      S_DRAIN: if (!bus.item_valid) state_n = S_FIN;
      S_FIN:   state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      ch_ptr  <= '0;
      reg_ptr <= '0;
      mask_q  <= '0;
    end else if (!abort) begin
      if (starting) begin
        mask_q  <= ch_mask;
        ch_ptr  <= first_ch;
        reg_ptr <= '0;
      end
      if (load_scan) begin
        ch_ptr  <= wrap ? adv_ch : scan_ch;
        reg_ptr <= wrap ? 3'd0 : scan_reg + 3'd1;
      end
    end
  end

  always_ff @(posedge spi_clk) begin
    if (rst || abort) begin
      bus.item_valid <= 1'b0;
      bus.item_addr  <= '0;
      bus.item_ch    <= '0;
      bus.item_reg   <= '0;
      bus.item_src   <= 1'b0;
      host_err       <= 1'b0;
    end else begin
      host_err <= host_gnt && !hdec.ok;
      if (slot_free) begin
        bus.item_valid <= host_ok || load_scan;
        if (host_ok) begin
          bus.item_addr <= host_addr;
          bus.item_ch   <= hdec.ch;
          bus.item_reg  <= hdec.rg;
          bus.item_src  <= 1'b1;
        end else if (load_scan) begin
          bus.item_addr <= scan_addr;
          bus.item_ch   <= scan_ch;
          bus.item_reg  <= scan_reg;
          bus.item_src  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_readout_scheduler.sv
// Self-checking bench for readout_scheduler: scripted scenarios plus
// randomized scans compared against an item-slot reference model.
module tb_readout_scheduler;

  logic       spi_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] ch_mask;
  logic       host_req;
  logic [6:0] host_addr;
  logic       host_gnt;
  logic       host_err;
  logic       busy;
  logic       done;

  int vectors     = 0;
  int miscompares = 0;

  readout_scheduler_if bus ();

  readout_scheduler dut (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .ch_mask  (ch_mask),
    .host_req (host_req),
    .host_addr(host_addr),
    .host_gnt (host_gnt),
    .host_err (host_err),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 spi_clk = ~spi_clk;

  task automatic tick;
    @(posedge spi_clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    ch_mask = 8'hFF; host_req = 1'b1; host_addr = 7'd20;
    bus.item_ready = 1'b1;
    tick; tick; #1;
    vectors++;
    if ({bus.item_valid, busy, done, host_err, host_gnt} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_ctl: v/busy/done/err/gnt=%b want 00000",
               {bus.item_valid, busy, done, host_err, host_gnt});
    end
    vectors++;
    if ({bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_fields: addr=%0d ch=%0d reg=%0d src=%b want 0",
               bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src);
    end
    rst = 1'b0; start = 1'b0; host_req = 1'b0;
    tick;
  endtask

  // rmode: 0 ready high, 1 ready 1,0,0,1 pattern, 2 random ready plus
  // stray start pulses and mask changes while busy. hrate>0 adds host reads.
  task automatic test_scan(input logic [7:0] m, input int rmode,
                           input int hrate, input string nm);
    int   q[$];
    int   n, dones, done_cyc, nscan, m_addr;
    logic m_valid, m_src, m_err, rdy, free, exp_gnt, exp_busy;
    for (int ch = 0; ch < 8; ch++)
      if (m[ch])
        for (int r = 0; r < 7; r++) q.push_back(11 + 7 * ch + r);
    n = q.size(); dones = 0; done_cyc = -1; nscan = 0;
    m_valid = 1'b0; m_src = 1'b0; m_err = 1'b0; m_addr = 0;
    for (int c = 0; c < 3000; c++) begin
      start = (c == 0);
      if (c == 0) ch_mask = m;
      if (c > 0 && rmode == 2 && dones == 0) begin
        start   = ($urandom % 8) == 0;
        ch_mask = 8'($urandom);
      end
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 4 == 0) || (c % 4 == 3);
        default: rdy = 1'($urandom % 2);
      endcase
      bus.item_ready = rdy;
      host_req  = (c > 0) && (hrate > 0) && (($urandom % hrate) == 0);
      host_addr = 7'($urandom_range(0, 80));
      #1;
      exp_busy = (c >= 1) && (dones == 0);
      exp_gnt  = host_req && (!m_valid || rdy);
      vectors++;
      if (bus.item_valid !== m_valid) begin
        miscompares++;
        $display("FAIL %s valid c=%0d: got %b want %b", nm, c, bus.item_valid, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if ({bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src} !==
            {7'(m_addr), 3'((m_addr - 11) / 7), 3'((m_addr - 11) % 7), m_src}) begin
          miscompares++;
          $display("FAIL %s item c=%0d: addr=%0d ch=%0d reg=%0d src=%b want %0d/%0d/%0d/%b",
                   nm, c, bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src,
                   m_addr, (m_addr - 11) / 7, (m_addr - 11) % 7, m_src);
        end
      end
      vectors++;
      if ({host_gnt, host_err, busy} !== {exp_gnt, m_err, exp_busy}) begin
        miscompares++;
        $display("FAIL %s gnt/err/busy c=%0d: got %b%b%b want %b%b%b", nm, c,
                 host_gnt, host_err, busy, exp_gnt, m_err, exp_busy);
      end
      if (done === 1'b1) begin
        dones++;
        done_cyc = c;
        vectors++;
        if (q.size() != 0) begin
          miscompares++;
          $display("FAIL %s early_done c=%0d: %0d scan items left want 0", nm, c, q.size());
        end
      end
      if (done_cyc >= 0 && c == done_cyc + 1) break;
      free = !m_valid || rdy;
      if (m_valid && rdy && !m_src) nscan++;
      m_err = 1'b0;
      if (free) begin
        if (host_req) begin
          if (host_addr >= 7'd11 && host_addr <= 7'd66) begin
            m_valid = 1'b1; m_src = 1'b1; m_addr = int'(host_addr);
          end else begin
            m_valid = 1'b0; m_err = 1'b1;
          end
        end else if (q.size() > 0) begin
          m_valid = 1'b1; m_src = 1'b0; m_addr = q.pop_front();
        end else begin
          m_valid = 1'b0;
        end
      end
      tick;
    end
    vectors++;
    if (dones != 1 || nscan != n) begin
      miscompares++;
      $display("FAIL %s totals: dones=%0d items=%0d want 1/%0d", nm, dones, nscan, n);
    end
    if (rmode == 0 && hrate == 0) begin
      vectors++;
      if (done_cyc != ((n > 0) ? n + 2 : 1)) begin
        miscompares++;
        $display("FAIL %s done_cycle: got %0d want %0d", nm, done_cyc,
                 (n > 0) ? n + 2 : 1);
      end
    end
    start = 1'b0; host_req = 1'b0; bus.item_ready = 1'b1;
    tick; tick;
  endtask

  task automatic test_host_priority;
    int c;
    bit found;
    ch_mask = 8'hFF; start = 1'b1; bus.item_ready = 1'b1; host_req = 1'b0;
    tick;
    start = 1'b0; c = 1; found = 1'b0;
    while (c < 40 && !found) begin
      #1;
      if (bus.item_valid && bus.item_addr == 7'd20) found = 1'b1;
      else begin tick; c++; end
    end
    vectors++;
    if (!found || c != 10) begin
      miscompares++;
      $display("FAIL host_wait20: found=%b cycle=%0d want 1/10", found, c);
    end
    host_req = 1'b1; host_addr = 7'd40;
    #1;
    vectors++;
    if (host_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL host_gnt: got %b want 1", host_gnt);
    end
    tick; c++;
    host_req = 1'b0;
    #1;
    vectors++;
    if ({bus.item_valid, bus.item_addr, bus.item_src, bus.item_ch, bus.item_reg} !==
        {1'b1, 7'd40, 1'b1, 3'd4, 3'd1}) begin
      miscompares++;
      $display("FAIL host_item: v=%b addr=%0d src=%b ch=%0d reg=%0d want 1/40/1/4/1",
               bus.item_valid, bus.item_addr, bus.item_src, bus.item_ch, bus.item_reg);
    end
    tick; c++;
    #1;
    vectors++;
    if ({bus.item_valid, bus.item_addr, bus.item_src} !== {1'b1, 7'd21, 1'b0}) begin
      miscompares++;
      $display("FAIL host_resume: v=%b addr=%0d src=%b want 1/21/0",
               bus.item_valid, bus.item_addr, bus.item_src);
    end
    while (c < 100 && done !== 1'b1) begin
      tick; c++; #1;
    end
    vectors++;
    if (c != 59) begin
      miscompares++;
      $display("FAIL host_done_cycle: got %0d want 59", c);
    end
    tick; tick;
  endtask

  task automatic test_bad_host;
    int bad[2] = '{5, 67};
    bus.item_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      host_addr = 7'(bad[i]); host_req = 1'b1;
      #1;
      vectors++;
      if (host_gnt !== 1'b1) begin
        miscompares++;
        $display("FAIL bad_gnt addr=%0d: got %b want 1", bad[i], host_gnt);
      end
      tick;
      host_req = 1'b0;
      #1;
      vectors++;
      if ({host_err, bus.item_valid, host_gnt} !== 3'b100) begin
        miscompares++;
        $display("FAIL bad_err addr=%0d: err/valid/gnt=%b want 100", bad[i],
                 {host_err, bus.item_valid, host_gnt});
      end
      tick;
      #1;
      vectors++;
      if ({host_err, bus.item_valid} !== 2'b00) begin
        miscompares++;
        $display("FAIL bad_pulse addr=%0d: err/valid=%b want 00", bad[i],
                 {host_err, bus.item_valid});
      end
    end
  endtask

  task automatic test_abort(input bit use_rst);
    bit found;
    int bad;
    ch_mask = 8'hFF; start = 1'b1; bus.item_ready = 1'b1; host_req = 1'b0;
    tick;
    start = 1'b0; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (bus.item_valid && bus.item_addr == 7'd30) found = 1'b1;
      else tick;
    end
    bus.item_ready = 1'b0;
    tick; #1;
    vectors++;
    if (!found || {bus.item_valid, bus.item_addr} !== {1'b1, 7'd30}) begin
      miscompares++;
      $display("FAIL stall30 rst=%b: found=%b v=%b addr=%0d want 1/1/30", use_rst,
               found, bus.item_valid, bus.item_addr);
    end
    if (use_rst) rst = 1'b1;
    else         abort = 1'b1;
    start = 1'b1; host_req = 1'b1; host_addr = 7'd40; bus.item_ready = 1'b1;
    #1;
    vectors++;
    if (host_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL cancel_gnt rst=%b: got %b want 0", use_rst, host_gnt);
    end
    tick; #1;
    vectors++;
    if ({bus.item_valid, busy, done, host_gnt, host_err} !== 5'b0) begin
      miscompares++;
      $display("FAIL cancel_ctl rst=%b: v/busy/done/gnt/err=%b want 00000", use_rst,
               {bus.item_valid, busy, done, host_gnt, host_err});
    end
    if (use_rst) begin
      vectors++;
      if ({bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src} !== 14'd0) begin
        miscompares++;
        $display("FAIL cancel_fields: addr=%0d ch=%0d reg=%0d src=%b want 0",
                 bus.item_addr, bus.item_ch, bus.item_reg, bus.item_src);
      end
    end
    rst = 1'b0; abort = 1'b0; start = 1'b0; host_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 70; i++) begin
      tick; #1;
      if (done !== 1'b0 || bus.item_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL cancel_quiet rst=%b: %0d active cycles want 0", use_rst, bad);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; ch_mask = 8'h00;
    host_req = 1'b0; host_addr = 7'd0; bus.item_ready = 1'b1;
    test_reset;
    test_scan(8'hFF, 0, 0, "full");
    test_scan(8'b1000_0101, 0, 0, "sparse");
    test_scan(8'hFF, 1, 0, "backpressure");
    test_scan(8'h00, 0, 0, "empty_mask");
    test_host_priority;
    test_bad_host;
    test_abort(1'b0);
    test_abort(1'b1);
    for (int i = 0; i < 6; i++) test_scan(8'($urandom), 2, 4, "random");
    test_scan(8'h81, 0, 0, "back_to_back");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
